hazard_detection_unit: RTL and testbench

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

---
 rtl/hazard_detection_unit.sv | 132 +++++++++++++
 tb/tb_hazard_detection_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// hazard_detection_unit
//
// Pipeline hazard controller. It detects load-use hazards between the decode
// stage and a load/pop sitting in ID/EX, flushes IF/ID on a taken branch, and
// freezes the whole pipeline while data memory is busy. A saturating counter
// records how many cycles the pipeline spent stalled or frozen.
//
// Ports
//   i_clk            pipeline clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_rs, i_rd       decode-stage source registers
//   i_rs_valid       decode instruction reads i_rs
//   i_rd_valid       decode instruction reads i_rd
//   i_rd_idex        destination register of the ID/EX instruction
//   i_mem_read_idex  ID/EX instruction is a load/pop
//   i_branch_taken   execute stage resolved a taken branch/jump
//   i_mem_busy       data memory cannot complete this cycle
//   i_clr_count      synchronous clear of the stall counter
//   o_stall          hold PC and IF/ID
//   o_bubble         zero ID/EX control signals
//   o_flush          clear IF/ID to NOP
//   o_freeze         hold every pipeline register
//   o_state          current FSM state
//   o_stall_count    cycles spent stalled or frozen (saturating)
//
// State table
//   state      | meaning
//   RUN        | normal issue; hazards evaluated every cycle
//   LOAD_STALL | one bubble inserted; load-use match ignored this cycle
//   MEM_WAIT   | pipeline frozen waiting on data memory
// ---------------------------------------------------------------------------
module hazard_detection_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_rs,
    input  logic [2:0]  i_rd,
    input  logic        i_rs_valid,
    input  logic        i_rd_valid,
    input  logic [2:0]  i_rd_idex,
    input  logic        i_mem_read_idex,
    input  logic        i_branch_taken,
    input  logic        i_mem_busy,
    input  logic        i_clr_count,
    output logic        o_stall,
    output logic        o_bubble,
    output logic        o_flush,
    output logic        o_freeze,
    output logic [1:0]  o_state,
    output logic [15:0] o_stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;
    logic        load_use;
    logic        stall_c;
    logic        bubble_c;
    logic        flush_c;
    logic        freeze_c;

    assign load_use = i_mem_read_idex &
                      ((i_rs_valid & (i_rs == i_rd_idex)) |
                       (i_rd_valid & (i_rd == i_rd_idex)));

    // MEM_WAIT shares RUN's rules: while busy it re-freezes and stays, and the
    // first non-busy cycle behaves exactly like RUN (a fresh load-use stall
    // can be raised in that same cycle).
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        state_d  = RUN;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (i_mem_busy) begin
                    freeze_c = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (i_branch_taken) begin
                    flush_c  = 1'b1;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                // The bubble has already been inserted, so the same match is
                // not allowed to stall a second cycle.
                if (i_mem_busy) begin
                    freeze_c = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (i_branch_taken) begin
                    flush_c  = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding 2'b11: outputs stay low, recover to RUN.
            end
        endcase
    end

    // Gate with reset so controls drop immediately, independent of the clock.
    assign o_stall       = stall_c  & i_rst_n;
    assign o_bubble      = bubble_c & i_rst_n;
    assign o_flush       = flush_c  & i_rst_n;
    assign o_freeze      = freeze_c & i_rst_n;
    assign o_state       = state_q;
    assign o_stall_count = count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (i_clr_count) begin
                count_q <= 16'h0000;
            end else if ((stall_c | freeze_c) && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_detection_unit
//
// Directed bench for hazard_detection_unit. Inputs change on the falling
// edge; combinational controls are sampled 1 ns later, registered state and
// counter 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_detection_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic        rs_valid;
    logic        rd_valid;
    logic [2:0]  rd_idex;
    logic        mem_read_idex;
    logic        branch_taken;
    logic        mem_busy;
    logic        clr_count;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        freeze;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_detection_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rs            (rs),
        .i_rd            (rd),
        .i_rs_valid      (rs_valid),
        .i_rd_valid      (rd_valid),
        .i_rd_idex       (rd_idex),
        .i_mem_read_idex (mem_read_idex),
        .i_branch_taken  (branch_taken),
        .i_mem_busy      (mem_busy),
        .i_clr_count     (clr_count),
        .o_stall         (stall),
        .o_bubble        (bubble),
        .o_flush         (flush),
        .o_freeze        (freeze),
        .o_state         (state),
        .o_stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control vector order: {stall, bubble, flush, freeze}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {12'h000, stall, bubble, flush, freeze}, {12'h000, exp});
    endtask

    task automatic drive(input logic busy, input logic br, input logic mr,
                         input logic [2:0] idex, input logic [2:0] s1, input logic v1,
                         input logic [2:0] s2, input logic v2, input logic clr);
        mem_busy      = busy;
        branch_taken  = br;
        mem_read_idex = mr;
        rd_idex       = idex;
        rs            = s1;
        rs_valid      = v1;
        rd            = s2;
        rd_valid      = v2;
        clr_count     = clr;
    endtask

    // Apply inputs at falling edge, check controls, then check registers
    // after the next rising edge.
    task automatic cycle(input string tag, input logic [3:0] exp_ctl,
                         input logic [1:0] exp_state, input logic [15:0] exp_count);
        #1;
        chk_ctl({tag, "_ctl"}, exp_ctl);
        @(posedge clk);
        #1;
        chk({tag, "_state"}, {14'h0, state}, {14'h0, exp_state});
        chk({tag, "_count"}, stall_count, exp_count);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        #2;
        chk_ctl("reset_ctl_busy", 4'b0000);
        chk("reset_state", {14'h0, state}, 16'h0000);
        chk("reset_count", stall_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs: one stall cycle, 00 -> 01 -> 00
        drive(1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("rs_match", 4'b1100, 2'b01, 16'd1);
        cycle("rs_suppress", 4'b0000, 2'b00, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("rs_idle", 4'b0000, 2'b00, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        cycle("clr1", 4'b0000, 2'b00, 16'd0);

        // Matching indices but neither source is read: no stall
        drive(1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0);
        cycle("novalid", 4'b0000, 2'b00, 16'd0);
        // Match on rd only
        drive(1'b0, 1'b0, 1'b1, 3'b101, 3'b000, 1'b1, 3'b101, 1'b1, 1'b0);
        cycle("rd_match", 4'b1100, 2'b01, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 1'b1, 3'b101, 1'b1, 1'b0);
        cycle("rd_done", 4'b0000, 2'b00, 16'd1);

        // Branch wins over load-use
        drive(1'b0, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("br_prio", 4'b0010, 2'b00, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        cycle("clr2", 4'b0000, 2'b00, 16'd0);

        // Memory busy 4 cycles entering from LOAD_STALL; branch during busy
        // must not flush
        drive(1'b0, 1'b0, 1'b1, 3'b011, 3'b011, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("ms_stall", 4'b1100, 2'b01, 16'd1);
        drive(1'b1, 1'b0, 1'b0, 3'b011, 3'b011, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("ms_busy1", 4'b0001, 2'b10, 16'd2);
        drive(1'b1, 1'b1, 1'b0, 3'b011, 3'b011, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("ms_busy2", 4'b0001, 2'b10, 16'd3);
        drive(1'b1, 1'b0, 1'b0, 3'b011, 3'b011, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("ms_busy3", 4'b0001, 2'b10, 16'd4);
        cycle("ms_busy4", 4'b0001, 2'b10, 16'd5);
        drive(1'b0, 1'b0, 1'b0, 3'b011, 3'b011, 1'b1, 3'd0, 1'b0, 1'b0);
        cycle("ms_release", 4'b0000, 2'b00, 16'd5);

        // Saturation: clear, then hold busy up to 16'hFFFE and beyond
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        cycle("clr3", 4'b0000, 2'b00, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", stall_count, 16'hFFFE);
        chk("sat_state", {14'h0, state}, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("sat_hold", stall_count, 16'hFFFF);
        end
        @(negedge clk);
        clr_count = 1'b1;
        cycle("clr_override", 4'b0001, 2'b10, 16'd0);
        clr_count = 1'b0;
        cycle("busy_again", 4'b0001, 2'b10, 16'd1);

        // Asynchronous reset between edges while frozen in MEM_WAIT
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("async_rst_ctl", 4'b0000);
        chk("async_rst_state", {14'h0, state}, 16'h0000);
        chk("async_rst_count", stall_count, 16'h0000);
        @(negedge clk);
        // First cycle after release evaluates RUN rules
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 3'b110, 3'b000, 1'b0, 3'b110, 1'b1, 1'b0);
        cycle("post_rst", 4'b1100, 2'b01, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
